exec_muldiv: RTL and testbench
==============================

# exec_muldiv

Parametrised multi-cycle multiply/divide unit with HI/LO registers, the sequential companion to the single-cycle execute ALU. It runs MIPS `mult`, `multu`, `div` and `divu` iteratively, one bit per cycle, and performs `mthi` and `mtlo` writes. It holds the architectural HI/LO pair and exposes a busy/done handshake so the controller can stall `mfhi`/`mflo` and any following mul/div. Operands come from the decoder read ports (rs, rt), and HI/LO feed the write-back mux.

## Interface
Parameters:
- `WIDTH`, default 32: operand and HI/LO width. Must be ≥ 4 and even.
- `CNT_W`, default `$clog2(WIDTH+1)`: iteration counter width. Derived; not overridden.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch request; accepted only when `busy`=0.
- `op`  in  3  operation select:
  - `000` mult, `001` multu, `010` div, `011` divu, `100` mthi, `101` mtlo.
  - `110` and `111` are no-ops: accepted, nothing changes, no `done`.
- `operand_a`  in  WIDTH  rs: multiplicand / dividend / mthi-mtlo source.
- `operand_b`  in  WIDTH  rt: multiplier / divisor.
- `cancel`  in  1  flush; aborts any operation in flight.
- `busy`  out  1  iterative operation in progress.
- `done`  out  1  one-cycle pulse when HI/LO have just been updated.
- `div_by_zero`  out  1  valid with `done`; high when a div/divu had `operand_b`=0.
- `hi_out`  out  WIDTH  architectural HI.
- `lo_out`  out  WIDTH  architectural LO.

## Operation
- FSM states: IDLE, MUL, DIV, FIX.
- Reset (async, `reset_n`=0):
  - State → IDLE.
  - `hi_out`, `lo_out`, `busy`, `done`, `div_by_zero` all 0.
  - Counter 0, internal datapath registers 0.
- IDLE + accepted start:
  - mult/multu → MUL. div/divu → DIV.
  - mthi/mtlo → write HI or LO from `operand_a` at that same edge and stay in IDLE.
- Operand latch at acceptance, for all four mul/div ops:
  - Signed ops store |a| and |b|, plus the result sign(s).
  - Unsigned ops store a and b directly.
  - Operand inputs are ignored after acceptance.
- MUL: radix-2 shift-add on a 2·WIDTH accumulator, WIDTH iterations, then → FIX.
- DIV: restoring division, WIDTH iterations (remainder WIDTH+1 bits), then → FIX.
- FIX:
  - Apply two's-complement sign correction.
  - Write HI/LO, assert `done` next cycle, return to IDLE.
- Results:
  - mult/multu: {HI,LO} = full 2·WIDTH product.
  - div/divu: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
- Boundary conditions:
  - Divisor 0: skip the iterations (DIV → FIX next cycle). LO = all ones, HI = `operand_a`, `div_by_zero`=1. Latency is still reported via `done`.
  - Signed MIN / −1: LO = MIN (wraps), HI = 0, `div_by_zero`=0.
  - `start` while `busy`=1: ignored, no effect on the running operation.
  - `cancel`=1 in any state: → IDLE at the next edge, `busy` falls, HI/LO unchanged, no `done`.
  - `cancel` and `start` in the same cycle: `cancel` wins; `start` is dropped.
  - `cancel` in the FIX cycle: HI/LO are not written.

## Timing
- Acceptance edge is k.
- mul/div:
  - `busy`=1 from k+1 through the FIX cycle.
  - Iterations run in cycles k+1..k+WIDTH; FIX runs in cycle k+WIDTH+1.
  - HI/LO update at the edge ending FIX.
  - In the following cycle: `done`=1, `busy`=0.
  - Total: WIDTH+2 cycles from acceptance to `done`.
- Divide-by-zero: FIX in cycle k+1, `done` in cycle k+2.
- mthi/mtlo: HI or LO updates at edge k. `done`=1 in cycle k+1. `busy` stays 0.
- Back-to-back: a new `start` can be accepted in the same cycle that `done` is high.
- `hi_out`/`lo_out` are direct register outputs. They change only at the single write edge and never show partial results.
- `done` and `div_by_zero` are registered one-cycle pulses.

## Test plan
All scenarios use WIDTH=32.
- Reset mid-MUL: `reset_n` low at cycle 10 → all outputs 0 immediately. After release, IDLE, with `busy`=0.
- mult a=0xFFFFFFFE (−2), b=0x00000003 → `done` at k+34, HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu a=7, b=2 → LO=3, HI=1.
- div a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0. divu a=5, b=0 → `done` at k+2, `div_by_zero`=1, LO=0xFFFFFFFF, HI=5.
- Pulse `start` (multu) while `busy` at iteration 5 → ignored, original result intact. `cancel` at iteration 20 → `busy` falls next cycle, HI/LO keep their prior values, no `done`.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 on consecutive cycles → HI and LO update on the respective edges, `done` each following cycle, `busy` never high.

Source files
------------

// File: rtl/exec_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : exec_muldiv
// Purpose  : Iterative multiply/divide unit holding the architectural HI/LO
//            pair. Executes mult/multu (radix-2 shift-add) and div/divu
//            (restoring division) one bit per cycle, plus single-edge
//            mthi/mtlo writes. busy/done let the controller stall readers.
// Ports    : i_clk, i_rst_n    clock (rising edge), async active-low reset
//            i_start, i_op     launch request (taken only when idle), opcode
//                              000 mult 001 multu 010 div 011 divu
//                              100 mthi 101 mtlo 11x no-op
//            i_operand_a/b     rs / rt operands, sampled at acceptance only
//            i_cancel          flush, overrides everything
//            o_busy            iterative operation in flight
//            o_done            one-cycle pulse after HI/LO were written
//            o_div_by_zero     qualifies o_done for a zero divisor
//            o_hi_out/o_lo_out architectural HI / LO
// Revision : 1.0  initial release
// ============================================================================
module exec_muldiv #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_operand_a,
   input  logic [WIDTH-1:0] i_operand_b,
   input  logic             i_cancel,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_div_by_zero,
   output logic [WIDTH-1:0] o_hi_out,
   output logic [WIDTH-1:0] o_lo_out
);

   localparam logic [2:0] c_OP_MULT  = 3'b000;
   localparam logic [2:0] c_OP_MULTU = 3'b001;
   localparam logic [2:0] c_OP_DIV   = 3'b010;
   localparam logic [2:0] c_OP_DIVU  = 3'b011;
   localparam logic [2:0] c_OP_MTHI  = 3'b100;
   localparam logic [2:0] c_OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_acc;      // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
   logic [WIDTH-1:0]     r_opnd;     // multiplicand or divisor magnitude
   logic                 r_neg_q;    // negate product / quotient in FIX
   logic                 r_neg_r;    // negate remainder in FIX (sign of dividend)
   logic                 r_is_div;
   logic                 r_dz_pend;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic                 r_done;
   logic                 r_dz;

   // ---------------------------------------------------------------- operands
   logic             w_is_mul;
   logic             w_is_div;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic             w_b_zero;

   assign w_is_mul = (i_op == c_OP_MULT) || (i_op == c_OP_MULTU);
   assign w_is_div = (i_op == c_OP_DIV)  || (i_op == c_OP_DIVU);
   // Signed variants are the even opcodes of the mul/div group.
   assign w_a_neg  = ~i_op[0] & i_operand_a[WIDTH-1];
   assign w_b_neg  = ~i_op[0] & i_operand_b[WIDTH-1];
   assign w_a_mag  = w_a_neg ? -i_operand_a : i_operand_a;
   assign w_b_mag  = w_b_neg ? -i_operand_b : i_operand_b;
   assign w_b_zero = (i_operand_b == '0);

   // ---------------------------------------------------------- iteration step
   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_mul_next;
   logic [WIDTH:0]     w_div_shift;
   logic               w_div_ge;
   logic [WIDTH-1:0]   w_div_sub;
   logic [2*WIDTH-1:0] w_div_next;

   assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
   assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

   // The trial difference is below the divisor whenever it is kept, so a
   // WIDTH-bit subtract is exact on the accepted path.
   assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
   assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_opnd;
   assign w_div_next  = w_div_ge ? {w_div_sub, r_acc[WIDTH-2:0], 1'b1}
                                 : {r_acc[2*WIDTH-2:0], 1'b0};

   // ------------------------------------------------------- sign correction
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_rem_src;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   assign w_prod    = r_neg_q ? -r_acc : r_acc;
   // With a zero divisor the iterations were skipped, so the low half still
   // holds |a|; restoring its sign yields the original dividend for HI.
   assign w_rem_src = r_dz_pend ? r_acc[WIDTH-1:0] : r_acc[2*WIDTH-1:WIDTH];
   assign w_rem     = r_neg_r ? -w_rem_src : w_rem_src;
   assign w_quo     = r_dz_pend ? '1 : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);

   // ------------------------------------------------------------------- FSM
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (i_cancel) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start && w_is_mul)      w_next = S_MUL;
               else if (i_start && w_is_div) w_next = w_b_zero ? S_FIX : S_DIV;
            end
            S_MUL:   if (r_cnt == CNT_W'(1)) w_next = S_FIX;
            S_DIV:   if (r_cnt == CNT_W'(1)) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   // -------------------------------------------------------------- datapath
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_opnd    <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_is_div  <= 1'b0;
         r_dz_pend <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_done    <= 1'b0;
         r_dz      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_dz   <= 1'b0;
         if (!i_cancel) begin
            case (r_state)
               S_IDLE: begin
                  if (i_start) begin
                     if (w_is_mul) begin
                        r_acc     <= {{WIDTH{1'b0}}, w_b_mag};
                        r_opnd    <= w_a_mag;
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= 1'b0;
                        r_is_div  <= 1'b0;
                        r_dz_pend <= 1'b0;
                        r_cnt     <= CNT_W'(WIDTH);
                     end else if (w_is_div) begin
                        r_acc     <= {{WIDTH{1'b0}}, w_a_mag};
                        r_opnd    <= w_b_mag;
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_is_div  <= 1'b1;
                        r_dz_pend <= w_b_zero;
                        r_cnt     <= CNT_W'(WIDTH);
                     end else if (i_op == c_OP_MTHI) begin
                        r_hi   <= i_operand_a;
                        r_done <= 1'b1;
                     end else if (i_op == c_OP_MTLO) begin
                        r_lo   <= i_operand_a;
                        r_done <= 1'b1;
                     end
                  end
               end
               S_MUL: begin
                  r_acc <= w_mul_next;
                  r_cnt <= r_cnt - CNT_W'(1);
               end
               S_DIV: begin
                  r_acc <= w_div_next;
                  r_cnt <= r_cnt - CNT_W'(1);
               end
               S_FIX: begin
                  if (r_is_div) begin
                     r_hi <= w_rem;
                     r_lo <= w_quo;
                  end else begin
                     r_hi <= w_prod[2*WIDTH-1:WIDTH];
                     r_lo <= w_prod[WIDTH-1:0];
                  end
                  r_done <= 1'b1;
                  r_dz   <= r_dz_pend;
                  r_cnt  <= '0;
               end
               default: ;
            endcase
         end
      end
   end

   assign o_busy        = (r_state != S_IDLE);
   assign o_done        = r_done;
   assign o_div_by_zero = r_dz;
   assign o_hi_out      = r_hi;
   assign o_lo_out      = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_exec_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_muldiv
// Purpose  : Directed self-checking bench for exec_muldiv (WIDTH=32).
//            Directed operations with hand-computed HI/LO, latency and flags.
// Revision : 1.0  initial release
// ============================================================================
module tb_exec_muldiv;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'b000;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        cancel = 1'b0;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int   total = 0;
   int   bad = 0;
   int   lat;
   logic bseen;
   logic bpost;
   logic dzd;

   exec_muldiv #(.WIDTH(32)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_start       (start),
      .i_op          (op),
      .i_operand_a   (a),
      .i_operand_b   (b),
      .i_cancel      (cancel),
      .o_busy        (busy),
      .o_done        (done),
      .o_div_by_zero (div_by_zero),
      .o_hi_out      (hi),
      .o_lo_out      (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Launches one operation; the acceptance edge is k and cycle k+i is the
   // period after the i-th rising edge. lat is the cycle index of done (0 if
   // none). poke_at injects a multu start, cancel_at asserts cancel.
   task automatic run_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                         input int poke_at, input int cancel_at, input int max_cyc,
                         output int l, output logic bs, output logic bp, output logic dz);
      @(negedge clk);
      start = 1'b1; op = o; a = aa; b = bb;
      l = 0; bs = 1'b0; bp = 1'b0; dz = 1'b0;
      for (int i = 1; i <= max_cyc; i++) begin
         @(posedge clk); #1;
         start = 1'b0; cancel = 1'b0;
         if (i == poke_at) begin start = 1'b1; op = 3'b001; a = 32'd3; b = 32'd3; end
         if (i == cancel_at) cancel = 1'b1;
         bs = bs | busy;
         if (cancel_at != 0 && i == cancel_at + 1) bp = busy;
         if (done) begin l = i; dz = div_by_zero; break; end
      end
      start = 1'b0; cancel = 1'b0;
   endtask

   initial begin
      // ---------------------------------------------------------- reset
      repeat (3) @(posedge clk);
      #1;
      check("rst_hi",   64'(hi), 64'h0);
      check("rst_lo",   64'(lo), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_done", 64'(done), 64'h0);
      check("rst_dz",   64'(div_by_zero), 64'h0);
      @(negedge clk); rst_n = 1'b1;

      // ------------------------------------------- mthi / mtlo back-to-back
      @(negedge clk); start = 1'b1; op = 3'b100; a = 32'h12345678; b = '0;
      @(posedge clk); #1;
      check("mthi_hi",   64'(hi), 64'h12345678);
      check("mthi_lo",   64'(lo), 64'h0);
      check("mthi_done", 64'(done), 64'h1);
      check("mthi_busy", 64'(busy), 64'h0);
      op = 3'b101; a = 32'h9ABCDEF0;
      @(posedge clk); #1;
      start = 1'b0;
      check("mtlo_lo",   64'(lo), 64'h9ABCDEF0);
      check("mtlo_hi",   64'(hi), 64'h12345678);
      check("mtlo_done", 64'(done), 64'h1);
      check("mtlo_busy", 64'(busy), 64'h0);
      @(posedge clk); #1;
      check("mt_done_off", 64'(done), 64'h0);

      // ----------------------------------------------------------- mult
      run_op(3'b000, 32'hFFFFFFFE, 32'h3, 0, 0, 60, lat, bseen, bpost, dzd);
      check("mult_lat", 64'(lat), 64'd34);
      check("mult_hi",  64'(hi), 64'hFFFFFFFF);
      check("mult_lo",  64'(lo), 64'hFFFFFFFA);
      check("mult_dz",  64'(dzd), 64'h0);
      check("mult_busy_done", 64'(busy), 64'h0);

      // back-to-back: issued in the done cycle
      run_op(3'b001, 32'hFFFFFFFE, 32'h3, 0, 0, 60, lat, bseen, bpost, dzd);
      check("multu_lat", 64'(lat), 64'd34);
      check("multu_hi",  64'(hi), 64'h2);
      check("multu_lo",  64'(lo), 64'hFFFFFFFA);

      // ------------------------------------------------------------ div
      run_op(3'b010, 32'hFFFFFFF9, 32'h2, 0, 0, 60, lat, bseen, bpost, dzd);
      check("div_lat", 64'(lat), 64'd34);
      check("div_lo",  64'(lo), 64'hFFFFFFFD);
      check("div_hi",  64'(hi), 64'hFFFFFFFF);

      run_op(3'b011, 32'h7, 32'h2, 0, 0, 60, lat, bseen, bpost, dzd);
      check("divu_lo", 64'(lo), 64'h3);
      check("divu_hi", 64'(hi), 64'h1);
      check("divu_dz", 64'(dzd), 64'h0);

      run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 0, 0, 60, lat, bseen, bpost, dzd);
      check("divmin_lo", 64'(lo), 64'h80000000);
      check("divmin_hi", 64'(hi), 64'h0);
      check("divmin_dz", 64'(dzd), 64'h0);

      // ---------------------------------------------------- divide by zero
      run_op(3'b011, 32'h5, 32'h0, 0, 0, 60, lat, bseen, bpost, dzd);
      check("dz_lat", 64'(lat), 64'd2);
      check("dz_flag", 64'(dzd), 64'h1);
      check("dz_lo", 64'(lo), 64'hFFFFFFFF);
      check("dz_hi", 64'(hi), 64'h5);
      @(posedge clk); #1;
      check("dz_flag_pulse", 64'(div_by_zero), 64'h0);

      run_op(3'b010, 32'hFFFFFFF9, 32'h0, 0, 0, 60, lat, bseen, bpost, dzd);
      check("sdz_lat", 64'(lat), 64'd2);
      check("sdz_hi",  64'(hi), 64'hFFFFFFF9);
      check("sdz_lo",  64'(lo), 64'hFFFFFFFF);

      // ------------------------------------------------ start while busy
      run_op(3'b001, 32'h00010000, 32'h00010000, 5, 0, 60, lat, bseen, bpost, dzd);
      check("poke_lat", 64'(lat), 64'd34);
      check("poke_hi",  64'(hi), 64'h1);
      check("poke_lo",  64'(lo), 64'h0);

      // ------------------------------------------------------------ cancel
      run_op(3'b000, 32'h5, 32'h7, 0, 20, 40, lat, bseen, bpost, dzd);
      check("cancel_no_done", 64'(lat), 64'd0);
      check("cancel_busy_was", 64'(bseen), 64'h1);
      check("cancel_busy_fall", 64'(bpost), 64'h0);
      check("cancel_hi", 64'(hi), 64'h1);
      check("cancel_lo", 64'(lo), 64'h0);

      // --------------------------------------------------- reset mid-MUL
      @(negedge clk); start = 1'b1; op = 3'b000; a = 32'h5; b = 32'h7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("midrst_busy_before", 64'(busy), 64'h1);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_busy", 64'(busy), 64'h0);
      check("midrst_hi",   64'(hi), 64'h0);
      check("midrst_lo",   64'(lo), 64'h0);
      check("midrst_done", 64'(done), 64'h0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("postrst_busy", 64'(busy), 64'h0);

      run_op(3'b011, 32'd100, 32'd7, 0, 0, 60, lat, bseen, bpost, dzd);
      check("postrst_lat", 64'(lat), 64'd34);
      check("postrst_lo",  64'(lo), 64'd14);
      check("postrst_hi",  64'(hi), 64'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute backstop in case a wait above is never satisfied.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
